// File: rtl/clock_setter_if.sv
// clock_setter_if
//   Bundles the debounced button levels going into the clock setter and the
//   staged BCD digits, load strobes and status levels coming out of it.
//   Ports (signals):
//     btn_mode, btn_alset, btn_inc, btn_dec, btn_alen, btn_stop : button levels
//     hr_in_1[1:0], hr_in_0[3:0], min_in_1[3:0], min_in_0[3:0]  : staged BCD time
//     LD_time, LD_alarm                                         : load strobes
//     AL_ON, STOP_alarm                                         : alarm levels
//     state_out[2:0]                                            : FSM state encoding
//   Modports: master = button driver / digit consumer, slave = clock_setter.
interface clock_setter_if;
  logic       btn_mode;
  logic       btn_alset;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_alen;
  logic       btn_stop;
  logic [1:0] hr_in_1;
  logic [3:0] hr_in_0;
  logic [3:0] min_in_1;
  logic [3:0] min_in_0;
  logic       LD_time;
  logic       LD_alarm;
  logic       AL_ON;
  logic       STOP_alarm;
  logic [2:0] state_out;

  modport master (
    output btn_mode, btn_alset, btn_inc, btn_dec, btn_alen, btn_stop,
    input  hr_in_1, hr_in_0, min_in_1, min_in_0,
    input  LD_time, LD_alarm, AL_ON, STOP_alarm, state_out
  );

  modport slave (
    input  btn_mode, btn_alset, btn_inc, btn_dec, btn_alen, btn_stop,
    output hr_in_1, hr_in_0, min_in_1, min_in_0,
    output LD_time, LD_alarm, AL_ON, STOP_alarm, state_out
  );
endinterface

// File: rtl/clock_setter.sv
// clock_setter
//   Button-driven editor for a 24h clock time and alarm time. Button rising
//   edges walk an FSM through hour/minute edit fields; the staged BCD digits
//   are then presented with a LD_time or LD_alarm strobe of LD_CYCLES cycles.
//   Edits left idle for TIMEOUT_CYCLES cycles are abandoned without a load.
//   Ports:
//     clk    : single clock, rising edge
//     areset : synchronous active-high reset
//     bus    : clock_setter_if.slave (buttons in, digits/strobes/status out)
module clock_setter #(
  parameter int LD_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           areset,
  clock_setter_if.slave bus
);

  localparam int              TW      = $clog2(TIMEOUT_CYCLES);
  localparam int              NBTN    = 6;
  localparam logic [7:0]      LD_LAST = 8'(LD_CYCLES - 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Bit positions in the packed button vector
  localparam int B_MODE  = 0;
  localparam int B_ALSET = 1;
  localparam int B_INC   = 2;
  localparam int B_DEC   = 3;
  localparam int B_ALEN  = 4;
  localparam int B_STOP  = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_HR   = 3'd1,
    S_T_MIN  = 3'd2,
    S_T_LOAD = 3'd3,
    S_A_HR   = 3'd4,
    S_A_MIN  = 3'd5,
    S_A_LOAD = 3'd6
  } state_t;

  state_t          r_state, w_state_next;
  logic [1:0]      r_hr1, w_hr1_next;
  logic [3:0]      r_hr0, w_hr0_next;
  logic [3:0]      r_min1, w_min1_next;
  logic [3:0]      r_min0, w_min0_next;
  logic [TW-1:0]   r_to_cnt, w_to_cnt_next;
  logic [7:0]      r_ld_cnt, w_ld_cnt_next;
  logic            r_al_on;
  logic            r_stop;

  logic [NBTN-1:0] w_btn;
  logic [NBTN-1:0] r_btn_prev;
  logic [NBTN-1:0] w_edge;
  logic            w_any_edge;
  logic            w_inc;
  logic            w_dec;
  logic            w_adj;
  logic [5:0]      w_hr_step;
  logic [7:0]      w_min_step;

  // ---------------------------------------------------------------------------
  // Button edge detection. History is cleared by reset, so a button held
  // through reset release registers as an edge on the first free cycle.
  // ---------------------------------------------------------------------------
  assign w_btn = {bus.btn_stop, bus.btn_alen, bus.btn_dec,
                  bus.btn_inc, bus.btn_alset, bus.btn_mode};

  always_ff @(posedge clk) begin
    if (areset) r_btn_prev <= '0;
    else        r_btn_prev <= w_btn;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_edge
      assign w_edge[gi] = w_btn[gi] & ~r_btn_prev[gi];
    end
  endgenerate

  assign w_any_edge = |w_edge;
  // A field adjust needs exactly one of inc/dec and no simultaneous mode edge
  assign w_inc = w_edge[B_INC] & ~w_edge[B_DEC] & ~w_edge[B_MODE];
  assign w_dec = w_edge[B_DEC] & ~w_edge[B_INC] & ~w_edge[B_MODE];
  assign w_adj = w_inc | w_dec;

  // ---------------------------------------------------------------------------
  // BCD field arithmetic with wrap; minutes never carry into hours.
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] hr_step(input logic [1:0] t, input logic [3:0] u,
                                         input logic up);
    logic [5:0] r;
    if (up) begin
      if (t == 2'd2 && u == 4'd3) r = 6'h00;
      else if (u == 4'd9)         r = {t + 2'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
      else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] min_step(input logic [3:0] t, input logic [3:0] u,
                                          input logic up);
    logic [7:0] r;
    if (up) begin
      if (t == 4'd5 && u == 4'd9) r = 8'h00;
      else if (u == 4'd9)         r = {t + 4'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 4'd0 && u == 4'd0) r = {4'd5, 4'd9};
      else if (u == 4'd0)         r = {t - 4'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  assign w_hr_step  = hr_step(r_hr1, r_hr0, w_inc);
  assign w_min_step = min_step(r_min1, r_min0, w_inc);

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_hr1    <= '0;
      r_hr0    <= '0;
      r_min1   <= '0;
      r_min0   <= '0;
      r_to_cnt <= '0;
      r_ld_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_hr1    <= w_hr1_next;
      r_hr0    <= w_hr0_next;
      r_min1   <= w_min1_next;
      r_min0   <= w_min0_next;
      r_to_cnt <= w_to_cnt_next;
      r_ld_cnt <= w_ld_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The timeout counter counts consecutive edge-free cycles
  // in an edit state; any edge (including alen/stop) restarts it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_hr1_next    = r_hr1;
    w_hr0_next    = r_hr0;
    w_min1_next   = r_min1;
    w_min0_next   = r_min0;
    w_to_cnt_next = '0;
    w_ld_cnt_next = '0;

    case (r_state)
      S_IDLE: begin
        if (w_edge[B_MODE])       w_state_next = S_T_HR;
        else if (w_edge[B_ALSET]) w_state_next = S_A_HR;
      end

      S_T_HR, S_A_HR, S_T_MIN, S_A_MIN: begin
        if (w_edge[B_MODE]) begin
          case (r_state)
            S_T_HR:  w_state_next = S_T_MIN;
            S_A_HR:  w_state_next = S_A_MIN;
            S_T_MIN: w_state_next = S_T_LOAD;
            default: w_state_next = S_A_LOAD;
          endcase
        end else begin
          if (w_adj) begin
            if (r_state == S_T_HR || r_state == S_A_HR)
              {w_hr1_next, w_hr0_next} = w_hr_step;
            else
              {w_min1_next, w_min0_next} = w_min_step;
          end
          if (!w_any_edge) begin
            if (r_to_cnt == TO_LAST) w_state_next  = S_IDLE;
            else                     w_to_cnt_next = r_to_cnt + 1'b1;
          end
        end
      end

      S_T_LOAD, S_A_LOAD: begin
        // Digits frozen; buttons ignored until the strobe has run its length
        if (r_ld_cnt == LD_LAST) w_state_next  = S_IDLE;
        else                     w_ld_cnt_next = r_ld_cnt + 8'd1;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Alarm enable / stop levels, independent of the FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (areset) begin
      r_al_on <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_stop <= bus.btn_stop;
      if (w_edge[B_ALEN]) r_al_on <= ~r_al_on;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode directly from the state register, so they are
  // mutually exclusive and low in every non-load state.
  // ---------------------------------------------------------------------------
  assign bus.hr_in_1    = r_hr1;
  assign bus.hr_in_0    = r_hr0;
  assign bus.min_in_1   = r_min1;
  assign bus.min_in_0   = r_min0;
  assign bus.LD_time    = (r_state == S_T_LOAD);
  assign bus.LD_alarm   = (r_state == S_A_LOAD);
  assign bus.AL_ON      = r_al_on;
  assign bus.STOP_alarm = r_stop;
  assign bus.state_out  = r_state;

endmodule

// File: doc/clock_setter.md
CLOCK_SETTER -- requirements
Module: clock_setter

Interface
REQ-001 Parameter LD_CYCLES, default 2: number of cycles LD_time/LD_alarm are held high per commit (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: idle cycles in an edit state before abandoning the edit (range 2..2^20).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 btn_mode  input  1  debounced level; rising edge starts a time edit or advances the edit field.
REQ-006 btn_alset  input  1  debounced level; rising edge in IDLE starts an alarm edit.
REQ-007 btn_inc  input  1  debounced level; rising edge increments the active field.
REQ-008 btn_dec  input  1  debounced level; rising edge decrements the active field.
REQ-009 btn_alen  input  1  debounced level; rising edge toggles AL_ON.
REQ-010 btn_stop  input  1  debounced level; drives STOP_alarm.
REQ-011 hr_in_1  output  2  staged hour tens digit, BCD.
REQ-012 hr_in_0  output  4  staged hour units digit, BCD.
REQ-013 min_in_1  output  4  staged minute tens digit, BCD.
REQ-014 min_in_0  output  4  staged minute units digit, BCD.
REQ-015 LD_time  output  1  load strobe for clock time.
REQ-016 LD_alarm  output  1  load strobe for alarm time.
REQ-017 AL_ON  output  1  alarm enable level.
REQ-018 STOP_alarm  output  1  alarm stop level.
REQ-019 state_out  output  3  current FSM state encoding (REQ-021).

Function
REQ-020 Rising edge on any btn_*: input high at cycle n, low at n-1; every resulting output change is visible at n+1.
REQ-021 FSM states / encoding: IDLE=0, T_HR=1, T_MIN=2, T_LOAD=3, A_HR=4, A_MIN=5, A_LOAD=6.
REQ-022 IDLE: btn_mode edge -> T_HR; btn_alset edge -> A_HR; both same cycle -> T_HR.
REQ-023 T_HR -> T_MIN and A_HR -> A_MIN on btn_mode edge; T_MIN -> T_LOAD and A_MIN -> A_LOAD on btn_mode edge.
REQ-024 T_LOAD / A_LOAD: LD_time / LD_alarm high for exactly LD_CYCLES cycles, then IDLE; button edges ignored in load states.
REQ-025 LD_time and LD_alarm never high simultaneously; both low outside load states.
REQ-026 Staged digits held stable throughout a load state.
REQ-027 Hour field inc, BCD: 23 -> 00, x9 -> (x+1)0, else units+1; dec: 00 -> 23, x0 -> (x-1)9, else units-1.
REQ-028 Minute field inc: 59 -> 00, x9 -> (x+1)0, else units+1; dec: 00 -> 59, x0 -> (x-1)9; no carry/borrow into hour.
REQ-029 inc and dec edges same cycle: no change; btn_mode edge with inc/dec same cycle: state advances, field unchanged.
REQ-030 inc/dec outside *_HR/*_MIN states: ignored.
REQ-031 Staged digits retained across edits (not cleared on entering T_HR/A_HR); shared by time and alarm paths.
REQ-032 Staged digits always valid BCD in range 00:00..23:59.
REQ-033 Timeout: in T_HR/T_MIN/A_HR/A_MIN, a counter reset by any btn_* edge; on reaching TIMEOUT_CYCLES consecutive edge-free cycles -> IDLE, no load strobe, staged digits retained.
REQ-034 AL_ON toggles on each btn_alen edge in any state, independent of FSM.
REQ-035 STOP_alarm = btn_stop registered one cycle (level follow, 1-cycle latency).

Reset
REQ-036 areset high at a clock edge: state IDLE, digits 00:00, LD_time=0, LD_alarm=0, AL_ON=0, STOP_alarm=0, timeout counter 0, edge history cleared to 0.
REQ-037 areset dominates all inputs; reset during a load state terminates the strobe on the next cycle.
REQ-038 A button held high through reset release produces an edge on the first post-reset cycle.

Verification
REQ-039 Reset, then mode, inc x1, mode, inc x20, mode -> digits 01:20, LD_time high exactly 2 cycles, state_out 3 -> 0, LD_alarm stays 0.
REQ-040 From 01:20: alset, dec x2, mode, mode -> staged 23:20, LD_alarm high 2 cycles, LD_time stays 0.
REQ-041 Minute wrap: staged xx:59, in T_MIN inc -> xx:00, hour unchanged; dec -> xx:59.
REQ-042 Timeout: enter T_HR, no buttons for 1000 cycles -> state IDLE, no strobe; edge at cycle 999 restarts the count.
REQ-043 Simultaneous: inc+dec same cycle -> no change; mode+inc in T_HR -> T_MIN, hour unchanged; btn_alen x3 -> AL_ON=1.
REQ-044 areset asserted in cycle 1 of T_LOAD -> LD_time low next cycle, digits 00:00, state_out 0.
